// File: rtl/eth_fcs_tx.sv
// Ethernet TX FCS generator: accumulates a reflected CRC-32 over header and payload
// bytes, then presents the four FCS bytes to the TX mux straight after the last byte.
module eth_fcs_tx #(
    parameter logic [31:0] POLY   = 32'hEDB88320,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       crc_start,
    input  logic       crc_en,
    input  logic [7:0] crc_data,
    input  logic       crc_last,
    output logic [7:0] fcs_tx_data,
    output logic       fcs_tx_done,
    output logic       fcs_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_crc;
    logic [31:0] w_crcNext;
    logic [31:0] r_fcs;
    logic [31:0] w_fcsNext;
    logic [1:0]  r_idx;
    logic [1:0]  w_idxNext;
    logic [31:0] w_crcUpd;

    // Eight LSB-first bit steps of the reflected CRC, unrolled into one cycle.
    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c;
        for (int i = 0; i < 8; i++) begin
            v = (v >> 1) ^ (POLY & {32{v[0] ^ d[i]}});
        end
        return v;
    endfunction

    assign w_crcUpd = crcByte(r_crc, crc_data);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_crc   <= INIT;
            r_fcs   <= 32'd0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_crc   <= w_crcNext;
            r_fcs   <= w_fcsNext;
            r_idx   <= w_idxNext;
        end
    end

    // A restart pulse in ACCUM wins over data and crc_last; the last byte is folded in
    // the same cycle so the FCS follows the payload with no gap.
    always_comb begin
        w_stateNext = r_state;
        w_crcNext   = r_crc;
        w_fcsNext   = r_fcs;
        w_idxNext   = r_idx;
        case (r_state)
            IDLE: begin
                if (crc_start) begin
                    w_crcNext   = INIT;
                    w_stateNext = ACCUM;
                end
            end
            ACCUM: begin
                if (crc_start) begin
                    w_crcNext = INIT;
                end else if (crc_last) begin
                    w_fcsNext   = (crc_en ? w_crcUpd : r_crc) ^ XOROUT;
                    w_idxNext   = 2'd0;
                    w_stateNext = EMIT;
                end else if (crc_en) begin
                    w_crcNext = w_crcUpd;
                end
            end
            EMIT: begin
                if (r_idx == 2'd3) begin
                    w_idxNext   = 2'd0;
                    w_stateNext = IDLE;
                end else begin
                    w_idxNext = r_idx + 2'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        fcs_tx_data = 8'd0;
        fcs_tx_done = 1'b0;
        if (r_state == EMIT) begin
            case (r_idx)
                2'd0:    fcs_tx_data = r_fcs[7:0];
                2'd1:    fcs_tx_data = r_fcs[15:8];
                2'd2:    fcs_tx_data = r_fcs[23:16];
                default: fcs_tx_data = r_fcs[31:24];
            endcase
            fcs_tx_done = (r_idx == 2'd3);
        end
    end

    assign fcs_busy = (r_state == ACCUM) || (r_state == EMIT);

endmodule

// File: doc/eth_fcs_tx.md
Name: eth_fcs_tx

Overview:
- Ethernet FCS generator for the TX path.
- Computes the IEEE 802.3 CRC-32 over every byte from destination MAC through the end of the payload (Ethernet header plus ARP data).
- Presents the 4 FCS bytes to the TX frame multiplexer's FCS input, one byte per cycle, immediately after the payload ends.
- Sits upstream of the TX mux. It taps the header/payload byte streams and drives the mux's fcs_tx_data/fcs_tx_done inputs.

Parameters:
- POLY, 32'hEDB88320, reflected CRC-32 polynomial.
- INIT, 32'hFFFFFFFF, CRC register value loaded at frame start.
- XOROUT, 32'hFFFFFFFF, value XORed onto the final CRC before transmission.

Ports:
- aclk  in  1  system clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- crc_start  in  1  one-cycle pulse marking a new frame; tied to preamble_sfd_tx_done.
- crc_en  in  1  crc_data carries a byte to be covered by the FCS this cycle.
- crc_data  in  8  header/payload byte, same cycle as it is presented to the mux.
- crc_last  in  1  final payload byte cycle; tied to arp_data_tx_done.
- fcs_tx_data  out  8  current FCS byte to the mux.
- fcs_tx_done  out  1  high during the cycle carrying the 4th (last) FCS byte.
- fcs_busy  out  1  high in ACCUM or EMIT.

Behaviour:
- Reset (async assert, sync release to first edge):
  - state=IDLE, crc=INIT, fcs_reg=0, idx=0.
  - fcs_tx_data=0, fcs_tx_done=0, fcs_busy=0.
- CRC update per byte:
  - Reflected, LSB-first, 8 unrolled bit steps in one cycle.
  - Each step: c = (c>>1) ^ (POLY & {32{c[0]^d[i]}}), for i = 0..7.
  - Only 32-bit width; no carry beyond bit 31.
- State IDLE:
  - crc_start=1 -> crc<=INIT, go to ACCUM.
  - crc_en/crc_data/crc_last are ignored, including when coincident with crc_start.
- State ACCUM:
  - crc_start=1 (priority over everything) -> crc<=INIT, stay in ACCUM. The byte that cycle is discarded and crc_last is ignored (frame restart).
  - crc_en=1, crc_last=0 -> crc<=update(crc, crc_data).
  - crc_last=1 -> f = crc_en ? update(crc, crc_data) : crc. Then fcs_reg<=f^XOROUT, idx<=0, go to EMIT.
  - The last byte is folded in the same cycle; zero-cycle gap before the FCS.
- State EMIT:
  - fcs_tx_data = fcs_reg[8*idx +: 8], taken directly from registers so it is valid in the same cycle the mux enters its FCS state.
  - Byte order is fcs_reg[7:0] first through fcs_reg[31:24] last.
  - idx increments each cycle.
  - fcs_tx_done = (idx==3), combinational from registered state.
  - idx==3 -> go to IDLE, idx<=0.
  - crc_start, crc_en and crc_last are ignored; EMIT always completes 4 bytes.
- Outside EMIT: fcs_tx_data=0, fcs_tx_done=0.
- Latency: crc_last at cycle N -> FCS bytes at cycles N+1..N+4, fcs_tx_done at N+4, IDLE at N+5.
- Back-to-back: crc_start at cycle N+5 or later starts the next frame normally.
- Empty frame: crc_last with no prior crc_en in ACCUM -> emits ~INIT^XOROUT-consistent value, i.e. the bytes of INIT^XOROUT (00 00 00 00 for defaults).
- Reset mid-operation (any state): immediate return to reset values. No partial FCS bytes appear after deassertion.

Test Plan:
- ASCII "123456789" (31..39), crc_en each byte, crc_last on 0x39 -> fcs_tx_data 26,39,F4,CB on N+1..N+4. fcs_tx_done only at N+4. CRC 0xCBF43926.
- Single byte 0x00 with crc_last -> FCS bytes 8D,EF,02,D2 (CRC 0xD202EF8D).
- 42-byte ARP request frame (broadcast dst, header + ARP payload) streamed with one-cycle crc_en gaps -> FCS equals software CRC-32 model; gaps do not change the result.
- crc_start mid-ACCUM after 5 bytes, then "123456789" -> FCS still 26,39,F4,CB. crc_start and crc_en pulsed during EMIT -> output bytes unchanged.
- aresetn asserted during EMIT at idx=1 -> next cycle outputs 0, busy=0. Next full frame after release produces the correct FCS.
- crc_last with no data -> 00,00,00,00 emitted. Two frames back-to-back (crc_start at N+5) -> both FCS values correct.
